traffic_light_monitor: RTL

Passive checker for a two-direction (NS/EW) intersection light interface. It samples the six lamp lines and the timing tick, and decodes the active phase. It checks that the phase order, lamp encoding and phase durations (in ticks) are correct, and raises sticky error flags with per-phase tick counts. It sits beside the light controller in simulation benches and on the FPGA top as a safety and debug monitor; it never drives the lamps.

---
 rtl/traffic_light_monitor.sv | 272 +++++++++++++++++++++++++++
 1 files changed

// File: rtl/traffic_light_monitor.sv
// Passive monitor for a two-direction (NS/EW) intersection light interface.
// Decodes the active phase and checks phase order, lamp encoding and phase durations.
// Errors are held in sticky flags.
// Optional feature macro: TLM_STALL_CHECK_EN flags an over-long LOCKED phase while it is still running.
module traffic_light_monitor #(
    parameter int T_NS_GREEN = 10,
    parameter int T_NS_AMBER = 3,
    parameter int T_ALL_RED  = 1,
    parameter int T_EW_GREEN = 10,
    parameter int T_EW_AMBER = 3,
    parameter int TOL        = 1,
    parameter int CW         = 16
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          tick,
    input  logic          ns_red,
    input  logic          ns_amber,
    input  logic          ns_green,
    input  logic          ew_red,
    input  logic          ew_amber,
    input  logic          ew_green,
    input  logic          clr,
    output logic [2:0]    phase,
    output logic          phase_valid,
    output logic          phase_done,
    output logic [CW-1:0] last_ticks,
    output logic [CW-1:0] cycle_count,
    output logic          err_conflict,
    output logic          err_encoding,
    output logic          err_sequence,
    output logic          err_timing,
    output logic          err_any
);

    typedef enum logic [1:0] {
        SYNC   = 2'd0,
        FIRST  = 2'd1,
        LOCKED = 2'd2
    } state_t;

    localparam logic [2:0] PH_NS_GREEN = 3'd0;
    localparam logic [2:0] PH_NS_AMBER = 3'd1;
    localparam logic [2:0] PH_ALL_RED1 = 3'd2;
    localparam logic [2:0] PH_EW_GREEN = 3'd3;
    localparam logic [2:0] PH_EW_AMBER = 3'd4;
    localparam logic [2:0] PH_ALL_RED2 = 3'd5;

    localparam logic [CW-1:0] CNT_MAX = '1;
    localparam logic [CW-1:0] CNT_ONE = {{(CW-1){1'b0}}, 1'b1};

    state_t        state_q, state_d;
    logic [2:0]    phase_q, phase_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          phase_valid_q, phase_valid_d;
    logic          phase_done_q, phase_done_d;
    logic [CW-1:0] last_ticks_q, last_ticks_d;
    logic [CW-1:0] cycle_q, cycle_d;
    logic          err_conflict_q, err_conflict_d;
    logic          err_encoding_q, err_encoding_d;
    logic          err_sequence_q, err_sequence_d;
    logic          err_timing_q, err_timing_d;
    logic          err_any_q, err_any_d;
`ifdef TLM_STALL_CHECK_EN
    logic          stall_q, stall_d;
`endif

    logic ns_r_only, ns_a_only, ns_g_only;
    logic ew_r_only, ew_a_only, ew_g_only;
    logic enc_ns_green, enc_ns_amber, enc_ew_green, enc_ew_amber, enc_all_red;
    logic enc_legal, enc_conflict;
    logic [2:0] samp_phase;
    logic samp_ok;
    logic new_conf, new_enc, new_seq, new_tim;
    int exp_lo, exp_hi;

    function automatic int t_nom(input logic [2:0] p);
        case (p)
            PH_NS_GREEN: return T_NS_GREEN;
            PH_NS_AMBER: return T_NS_AMBER;
            PH_ALL_RED1: return T_ALL_RED;
            PH_EW_GREEN: return T_EW_GREEN;
            PH_EW_AMBER: return T_EW_AMBER;
            PH_ALL_RED2: return T_ALL_RED;
            default:     return 0;
        endcase
    endfunction

    function automatic logic [2:0] succ(input logic [2:0] p);
        return (p == PH_ALL_RED2) ? PH_NS_GREEN : p + 3'd1;
    endfunction

    // Lamp decode: one lamp per direction, and at least one direction red.
    always_comb begin
        ns_r_only    = ns_red & ~ns_amber & ~ns_green;
        ns_a_only    = ~ns_red & ns_amber & ~ns_green;
        ns_g_only    = ~ns_red & ~ns_amber & ns_green;
        ew_r_only    = ew_red & ~ew_amber & ~ew_green;
        ew_a_only    = ~ew_red & ew_amber & ~ew_green;
        ew_g_only    = ~ew_red & ~ew_amber & ew_green;
        enc_ns_green = ns_g_only & ew_r_only;
        enc_ns_amber = ns_a_only & ew_r_only;
        enc_ew_green = ns_r_only & ew_g_only;
        enc_ew_amber = ns_r_only & ew_a_only;
        enc_all_red  = ns_r_only & ew_r_only;
        enc_legal    = enc_ns_green | enc_ns_amber | enc_ew_green | enc_ew_amber | enc_all_red;
        enc_conflict = (ns_green | ns_amber) & (ew_green | ew_amber);
    end

    // All-red resolves from the tracked phase; all-red right after a green has no valid meaning.
    always_comb begin
        samp_phase = phase_q;
        samp_ok    = 1'b1;
        if (enc_ns_green) begin
            samp_phase = PH_NS_GREEN;
        end else if (enc_ns_amber) begin
            samp_phase = PH_NS_AMBER;
        end else if (enc_ew_green) begin
            samp_phase = PH_EW_GREEN;
        end else if (enc_ew_amber) begin
            samp_phase = PH_EW_AMBER;
        end else if (phase_q == PH_NS_AMBER || phase_q == PH_ALL_RED1) begin
            samp_phase = PH_ALL_RED1;
        end else if (phase_q == PH_EW_AMBER || phase_q == PH_ALL_RED2) begin
            samp_phase = PH_ALL_RED2;
        end else begin
            samp_ok = 1'b0;
        end
    end

    always_comb begin
        exp_lo = (t_nom(phase_q) == 0) ? 0 : t_nom(phase_q) - 1;
        exp_hi = exp_lo + TOL;
    end

    always_comb begin
        state_d      = state_q;
        phase_d      = phase_q;
        cnt_d        = cnt_q;
        phase_done_d = 1'b0;
        last_ticks_d = last_ticks_q;
        cycle_d      = cycle_q;
        new_conf     = enc_conflict;
        new_enc      = 1'b0;
        new_seq      = 1'b0;
        new_tim      = 1'b0;
`ifdef TLM_STALL_CHECK_EN
        stall_d      = stall_q;
`endif

        case (state_q)
            SYNC: begin
                cnt_d = '0;
`ifdef TLM_STALL_CHECK_EN
                stall_d = 1'b0;
`endif
                if (enc_ns_green || enc_ew_green) begin
                    state_d = FIRST;
                    phase_d = enc_ns_green ? PH_NS_GREEN : PH_EW_GREEN;
                    cnt_d   = tick ? CNT_ONE : '0;
                end
            end

            FIRST, LOCKED: begin
                if (!enc_legal) begin
                    new_enc = 1'b1;
                    state_d = SYNC;
                    cnt_d   = '0;
                end else if (samp_ok && samp_phase == phase_q) begin
                    if (tick && cnt_q != CNT_MAX) begin
                        cnt_d = cnt_q + CNT_ONE;
                    end
`ifdef TLM_STALL_CHECK_EN
                    if (state_q == LOCKED && !stall_q && int'(cnt_d) > exp_hi) begin
                        new_tim = 1'b1;
                        stall_d = 1'b1;
                    end
`endif
                end else if (samp_ok && samp_phase == succ(phase_q)) begin
                    phase_done_d = 1'b1;
                    last_ticks_d = cnt_q;
                    if (state_q == LOCKED && (int'(cnt_q) < exp_lo || int'(cnt_q) > exp_hi)) begin
                        new_tim = 1'b1;
                    end
                    if (state_q == LOCKED && phase_q == PH_ALL_RED2 && cycle_q != CNT_MAX) begin
                        cycle_d = cycle_q + CNT_ONE;
                    end
                    state_d = LOCKED;
                    phase_d = samp_phase;
                    cnt_d   = tick ? CNT_ONE : '0;
`ifdef TLM_STALL_CHECK_EN
                    stall_d = 1'b0;
`endif
                end else begin
                    new_seq = 1'b1;
`ifdef TLM_STALL_CHECK_EN
                    stall_d = 1'b0;
`endif
                    if (enc_ns_green || enc_ew_green) begin
                        state_d = FIRST;
                        phase_d = samp_phase;
                        cnt_d   = tick ? CNT_ONE : '0;
                    end else begin
                        state_d = SYNC;
                        cnt_d   = '0;
                    end
                end
            end

            default: begin
                state_d = SYNC;
                cnt_d   = '0;
            end
        endcase

        phase_valid_d  = (state_d != SYNC);
        // A freshly detected error wins over a simultaneous clear.
        err_conflict_d = (err_conflict_q & ~clr) | new_conf;
        err_encoding_d = (err_encoding_q & ~clr) | new_enc;
        err_sequence_d = (err_sequence_q & ~clr) | new_seq;
        err_timing_d   = (err_timing_q & ~clr) | new_tim;
        err_any_d      = err_conflict_d | err_encoding_d | err_sequence_d | err_timing_d;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q        <= SYNC;
            phase_q        <= '0;
            cnt_q          <= '0;
            phase_valid_q  <= 1'b0;
            phase_done_q   <= 1'b0;
            last_ticks_q   <= '0;
            cycle_q        <= '0;
            err_conflict_q <= 1'b0;
            err_encoding_q <= 1'b0;
            err_sequence_q <= 1'b0;
            err_timing_q   <= 1'b0;
            err_any_q      <= 1'b0;
`ifdef TLM_STALL_CHECK_EN
            stall_q        <= 1'b0;
`endif
        end else begin
            state_q        <= state_d;
            phase_q        <= phase_d;
            cnt_q          <= cnt_d;
            phase_valid_q  <= phase_valid_d;
            phase_done_q   <= phase_done_d;
            last_ticks_q   <= last_ticks_d;
            cycle_q        <= cycle_d;
            err_conflict_q <= err_conflict_d;
            err_encoding_q <= err_encoding_d;
            err_sequence_q <= err_sequence_d;
            err_timing_q   <= err_timing_d;
            err_any_q      <= err_any_d;
`ifdef TLM_STALL_CHECK_EN
            stall_q        <= stall_d;
`endif
        end
    end

    assign phase        = phase_q;
    assign phase_valid  = phase_valid_q;
    assign phase_done   = phase_done_q;
    assign last_ticks   = last_ticks_q;
    assign cycle_count  = cycle_q;
    assign err_conflict = err_conflict_q;
    assign err_encoding = err_encoding_q;
    assign err_sequence = err_sequence_q;
    assign err_timing   = err_timing_q;
    assign err_any      = err_any_q;

endmodule
